dyn_branch_predictor: RTL
=========================

Name: dyn_branch_predictor

Overview:
Parametrised dynamic branch predictor for the pipelined RISC-V core. It replaces the fixed 1-bit bimodal predictor and adds a direct-mapped branch target buffer (BTB), a speculative global history register (GHR) for gshare indexing, misprediction history repair, and performance counters. Lookup is driven from IF with the current PC. Updates come from the stage that resolves branches (EX/MEM).

Parameters:
PHT_ENTRIES, 64, pattern-history-table entries; power of 2, >=4; PHT_IDX_W = log2(PHT_ENTRIES)
CTR_BITS, 2, saturating counter width, 1..4
HIST_LEN, 6, GHR length, 0..PHT_IDX_W; 0 selects pure bimodal (no XOR, GHR unused)
BTB_ENTRIES, 32, BTB entries; power of 2; BTB_IDX_W = log2(BTB_ENTRIES)
TAG_W, 10, BTB tag width, taken from PC[TAG_W+BTB_IDX_W+1 : BTB_IDX_W+2]

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pred_req  in  1  IF lookup valid (low during stall); enables speculative GHR shift
pred_pc  in  64  IF program counter
pred_taken  out  1  predicted taken (BTB hit AND counter MSB)
pred_hit  out  1  BTB tag hit
pred_next_pc  out  64  pred_taken ? BTB target : pred_pc+4
pred_ghr  out  HIST_LEN (min 1)  GHR snapshot used for this lookup; pipelined with the branch
upd_valid  in  1  resolved conditional branch
upd_pc  in  64  PC of resolved branch
upd_taken  in  1  actual outcome
upd_target  in  64  actual taken target
upd_ghr  in  HIST_LEN (min 1)  pred_ghr carried with this branch
upd_mispredict  in  1  direction or target was wrong; qualified by upd_valid
stat_branches  out  32  resolved-branch count
stat_mispredicts  out  32  misprediction count

Behaviour:
- Lookup is purely combinational from pred_pc and current state (0-cycle latency).
- PHT index = pred_pc[PHT_IDX_W+1:2] XOR zero-extended GHR. When HIST_LEN=0 the index is the PC bits only.
- BTB index = pred_pc[BTB_IDX_W+1:2]. Hit = valid && stored tag == PC tag field.
- All state writes occur on the rising clk edge. A lookup in the same cycle as an update to the same entry sees the old value (no bypass).
- PHT update on upd_valid:
  - Index = upd_pc[PHT_IDX_W+1:2] XOR upd_ghr. The current GHR is never used for updates.
  - Counter +1 if upd_taken, -1 otherwise, saturating at 2^CTR_BITS-1 and 0.
- BTB update on upd_valid && upd_taken: write valid=1, tag, upd_target. A not-taken outcome never allocates or invalidates an entry.
- GHR, in priority order per cycle:
  1. upd_valid && upd_mispredict: GHR <= {upd_ghr[HIST_LEN-2:0], upd_taken} (repair). Any same-cycle speculative shift is discarded.
  2. Else pred_req && pred_hit: GHR <= {GHR[HIST_LEN-2:0], pred_taken} (speculative shift).
  3. Else hold.
- Statistics counters:
  - stat_branches +1 on each upd_valid.
  - stat_mispredicts +1 on each upd_valid && upd_mispredict.
  - Both saturate at 0xFFFFFFFF; no wrap.
- Reset, asynchronous when reset=0:
  - All PHT counters to weakly-not-taken, 2^(CTR_BITS-1)-1 (1 when CTR_BITS=1 maps to value 0).
  - All BTB valid bits 0; GHR 0; statistics 0.
  - Resulting outputs: pred_taken=0, pred_hit=0, pred_next_pc=pred_pc+4, pred_ghr=0.
  - Reset asserted mid-operation discards all training, including any in-flight update.
  - Table reset is via a flop array, not an iterative clear, so there are no reset busy cycles.
- pred_pc+4 wraps modulo 2^64.
- upd_mispredict without upd_valid is ignored.

Decomposition:
- Shared package bp_pkg:
  - counter increment/decrement saturate functions
  - weakly-not-taken constant function of CTR_BITS
  - BTB entry struct {valid, tag, target}
  - index-hash function
- One natural sub-module: sat_counter_table (PHT_ENTRIES x CTR_BITS array with combinational read port and synchronous saturating update port). The BTB and GHR stay in the top level.

Test Plan:
1. Reset with pred_pc=0x100 -> pred_taken=0, pred_hit=0, pred_next_pc=0x104, stats=0.
2. Train with HIST_LEN=0: four updates pc=0x100, taken, target 0x40 -> pred_hit=1, pred_taken=1, pred_next_pc=0x40. Ten further taken updates -> counter stays at 3; one not-taken update -> still predicts taken.
3. Gshare pattern with HIST_LEN=6: branch at 0x200 alternates T/N with correct upd_ghr fed back over 40 resolutions -> the final 10 lookups match the alternation exactly.
4. Speculation and repair: three BTB-hit lookups with pred_req=1 shift the GHR (GHR=0b000111). Then upd_mispredict with upd_ghr=0b000010, taken=0 -> GHR=0b000100 next cycle.
5. Same cycle pred_req plus BTB hit and mispredict update -> GHR equals repair value only; stat_mispredicts increments by exactly 1.
6. Reset asserted asynchronously between clock edges after training -> outputs return to step-1 values immediately, before the next clk edge.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor: saturating counter math,
// BTB entry layout and the gshare index hash.
package bp_pkg;

    localparam int unsigned MAX_CTR_BITS = 4;
    localparam int unsigned MAX_TAG_W    = 32;
    localparam int unsigned MAX_IDX_W    = 32;

    typedef logic [MAX_CTR_BITS-1:0] ctrT;

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic [63:0]          target;
    } btbEntryT;

    function automatic ctrT ctrMax(int unsigned bits);
        return ctrT'((1 << bits) - 1);
    endfunction

    function automatic ctrT satInc(ctrT v, int unsigned bits);
        return (v >= ctrMax(bits)) ? v : v + 1'b1;
    endfunction

    function automatic ctrT satDec(ctrT v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    // 2^(bits-1)-1, which degenerates to 0 for a 1-bit counter
    function automatic ctrT weakNotTaken(int unsigned bits);
        return ctrT'((1 << (bits - 1)) - 1);
    endfunction

    function automatic logic [MAX_IDX_W-1:0] phtHash(logic [63:0] pc,
                                                     logic [MAX_IDX_W-1:0] hist,
                                                     int unsigned idxW);
        logic [MAX_IDX_W-1:0] mask;
        mask = MAX_IDX_W'((64'd1 << idxW) - 64'd1);
        return (pc[MAX_IDX_W+1:2] ^ hist) & mask;
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Pattern history table: array of saturating counters with a combinational read port
// and a synchronous increment/decrement port.
module sat_counter_table
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(ENTRIES)-1:0] rdIdx,
    output logic [CTR_BITS-1:0]        rdCtr,
    input  logic                       wrEn,
    input  logic [$clog2(ENTRIES)-1:0] wrIdx,
    input  logic                       wrTaken
);

    localparam ctrT WNT = weakNotTaken(CTR_BITS);

    logic [CTR_BITS-1:0] ctrQ [ENTRIES];
    ctrT                 wrOld;
    ctrT                 wrNew;
    logic                unusedBits;

    assign rdCtr = ctrQ[rdIdx];

    always_comb begin
        wrOld = '0;
        wrOld[CTR_BITS-1:0] = ctrQ[wrIdx];
        wrNew = wrTaken ? satInc(wrOld, CTR_BITS) : satDec(wrOld);
    end

    assign unusedBits = ^wrNew;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctrQ[i] <= WNT[CTR_BITS-1:0];
            end
        end else if (wrEn) begin
            ctrQ[wrIdx] <= wrNew[CTR_BITS-1:0];
        end
    end

endmodule

// File: rtl/dyn_branch_predictor.sv
// Gshare/bimodal direction predictor with a direct-mapped BTB, speculative global history
// with misprediction repair, and saturating resolution statistics.
module dyn_branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned PHT_ENTRIES = 64,
    parameter int unsigned CTR_BITS    = 2,
    parameter int unsigned HIST_LEN    = 6,
    parameter int unsigned BTB_ENTRIES = 32,
    parameter int unsigned TAG_W       = 10,
    localparam int unsigned GHR_W      = (HIST_LEN == 0) ? 1 : HIST_LEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_req,
    input  logic [63:0]      pred_pc,
    output logic             pred_taken,
    output logic             pred_hit,
    output logic [63:0]      pred_next_pc,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [63:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [63:0]      upd_target,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_mispredict,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
);

    localparam int unsigned PHT_IDX_W = $clog2(PHT_ENTRIES);
    localparam int unsigned BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_LSB   = BTB_IDX_W + 2;

    logic [GHR_W-1:0]     ghrQ, ghrD;
    logic [MAX_IDX_W-1:0] predHist, updHist, predHashFull, updHashFull;
    logic [PHT_IDX_W-1:0] predPhtIdx, updPhtIdx;
    logic [CTR_BITS-1:0]  predCtr;
    logic [BTB_IDX_W-1:0] predBtbIdx, updBtbIdx;
    logic [MAX_TAG_W-1:0] predTag, updTag;
    btbEntryT             btbQ [BTB_ENTRIES];
    btbEntryT             predEntry;
    logic [31:0]          statBrQ, statBrD, statMpQ, statMpD;
    logic                 unusedBits;

    // History is zero-extended into the index; with HIST_LEN=0 it is forced to zero.
    always_comb begin
        predHist = '0;
        updHist  = '0;
        if (HIST_LEN != 0) begin
            predHist[GHR_W-1:0] = ghrQ;
            updHist[GHR_W-1:0]  = upd_ghr;
        end
        predHashFull = phtHash(pred_pc, predHist, PHT_IDX_W);
        updHashFull  = phtHash(upd_pc, updHist, PHT_IDX_W);
        predPhtIdx   = predHashFull[PHT_IDX_W-1:0];
        updPhtIdx    = updHashFull[PHT_IDX_W-1:0];
    end

    sat_counter_table #(
        .ENTRIES  (PHT_ENTRIES),
        .CTR_BITS (CTR_BITS)
    ) u_pht (
        .clk     (clk),
        .reset   (reset),
        .rdIdx   (predPhtIdx),
        .rdCtr   (predCtr),
        .wrEn    (upd_valid),
        .wrIdx   (updPhtIdx),
        .wrTaken (upd_taken)
    );

    always_comb begin
        predTag = '0;
        updTag  = '0;
        predTag[TAG_W-1:0] = pred_pc[TAG_LSB +: TAG_W];
        updTag[TAG_W-1:0]  = upd_pc[TAG_LSB +: TAG_W];
        predBtbIdx = pred_pc[2 +: BTB_IDX_W];
        updBtbIdx  = upd_pc[2 +: BTB_IDX_W];
        predEntry  = btbQ[predBtbIdx];
    end

    assign pred_hit     = predEntry.valid && (predEntry.tag == predTag);
    assign pred_taken   = pred_hit && predCtr[CTR_BITS-1];
    assign pred_next_pc = pred_taken ? predEntry.target : pred_pc + 64'd4;
    assign pred_ghr     = ghrQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btbQ[i] <= '0;
            end
        end else if (upd_valid && upd_taken) begin
            btbQ[updBtbIdx] <= '{valid: 1'b1, tag: updTag, target: upd_target};
        end
    end

    // Repair from the resolved branch beats any speculative shift in the same cycle.
    always_comb begin
        ghrD = ghrQ;
        if (HIST_LEN != 0) begin
            if (upd_valid && upd_mispredict) begin
                ghrD = GHR_W'({upd_ghr, upd_taken});
            end else if (pred_req && pred_hit) begin
                ghrD = GHR_W'({ghrQ, pred_taken});
            end
        end
    end

    always_comb begin
        statBrD = statBrQ;
        statMpD = statMpQ;
        if (upd_valid && (statBrQ != '1)) begin
            statBrD = statBrQ + 32'd1;
        end
        if (upd_valid && upd_mispredict && (statMpQ != '1)) begin
            statMpD = statMpQ + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghrQ    <= '0;
            statBrQ <= '0;
            statMpQ <= '0;
        end else begin
            ghrQ    <= ghrD;
            statBrQ <= statBrD;
            statMpQ <= statMpD;
        end
    end

    assign stat_branches    = statBrQ;
    assign stat_mispredicts = statMpQ;

    assign unusedBits = ^{pred_pc, upd_pc, upd_ghr, predHashFull, updHashFull};

endmodule
